tick_divider: RTL and testbench
===============================

Name: tick_divider

Overview:
- Parametrised multi-channel clock-enable generator. Successor to the fixed two-divider scheme: the RTC divider (clk_freq/rtc_freq)/2-1 and the slow divider clk_freq/slow_freq.
- Each channel derives a one-cycle tick pulse and a 50%-duty toggle from the single core clock. Divisors can be reprogrammed at run time.
- Sits beside CLINT/UART. Feeds mtime increment, UART baud and slow-peripheral enables.
- Adds run-time divisor writes, per-channel enable/hold and a per-channel wrapping tick counter.

Parameters:
- num_ch, 2, number of independent divider channels (1..16).
- div_width, 16, width of each divisor and phase counter.
- cnt_width, 32, width of each per-channel tick event counter.
- div_default, {16'd9, 16'd4}, packed num_ch*div_width reset divisors; channel i is at slice [i*div_width +: div_width]. Ch0=4 is the RTC divider at 100/10 MHz; ch1=9 is the slow divider, period 10.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous reset, active-high.
- enable  in  num_ch  per-channel run enable.
- wr_valid  in  1  divisor write request.
- wr_ch  in  $clog2(num_ch) (min 1)  target channel.
- wr_div  in  div_width  new terminal value; period is wr_div+1 cycles.
- wr_ready  out  1  write accepted this cycle.
- wr_err  out  1  registered pulse: write to channel >= num_ch.
- div_o  out  num_ch*div_width  current divisor per channel.
- tick_o  out  num_ch  registered one-cycle tick per channel.
- toggle_o  out  num_ch  registered square output per channel.
- cnt_o  out  num_ch*cnt_width  ticks emitted per channel, wrapping.

Behaviour:
- Reset (synchronous, active-high): phase=0, div=div_default slice, tick_o=0, toggle_o=0, cnt_o=0, wr_err=0, wr_ready=0.
  - Reset asserted mid-period aborts the period. Counting restarts from 0 on the first cycle after reset deasserts.
- Per channel, enable=1, no write:
  - phase==div: phase<=0, tick_o<=1, toggle_o<=~toggle_o, cnt<=cnt+1 (mod 2^cnt_width).
  - Otherwise: phase<=phase+1, tick_o<=0.
  - Tick period is div+1 cycles; toggle period is 2*(div+1) cycles.
- div==0: tick_o is high every cycle and toggle_o flips every cycle.
- First tick after reset is high in the cycle following the div+1-th enabled edge. Example: div=4 gives tick_o high in cycle 5, counting the first post-reset edge as cycle 1.
- enable=0: phase, toggle and cnt hold; tick_o<=0. Re-enable resumes from the held phase, with no reset of phase.
- Write handshake:
  - wr_ready = ~reset, combinational; one write accepted per cycle when wr_valid && wr_ready.
  - Valid channel: div[wr_ch]<=wr_div, phase[wr_ch]<=0, tick_o[wr_ch]<=0 that cycle. Toggle and cnt are unchanged.
  - The write takes effect on the same edge, independent of enable.
  - Write coinciding with terminal count: write wins, no tick, toggle/cnt not advanced.
- Invalid channel (wr_ch>=num_ch, only possible when num_ch is not a power of 2): no state change; wr_err<=1 for one cycle.
- div_o reflects the new value on the cycle after the accepting edge.
- Other channels are unaffected by writes to a given channel.
- All outputs are registered except wr_ready. No combinational path from wr_* to tick_o/toggle_o.

Test Plan:
- Reset, defaults, all enabled for 40 cycles -> ch0 tick every 5 cycles (first in cycle 5), toggle period 10; ch1 tick every 10 cycles; cnt_o ch0=8, ch1=4 at cycle 40.
- Write ch0 wr_div=0 -> tick_o[0] high every cycle from the second cycle after the write; toggle_o[0] alternates; div_o[0]=0.
- Write ch1 wr_div=2 exactly on the cycle phase[1]==9 -> no tick that edge, cnt[1] unchanged, next tick 3 cycles later.
- enable[0] low for 7 cycles at phase 2 -> tick_o[0]=0 and toggle held throughout; after re-enable, the next tick arrives after 2 further cycles (phase 3..4).
- num_ch=3, write wr_ch=3 -> wr_err pulse for exactly 1 cycle; all div_o unchanged.
- Reset asserted at phase 3 of ch0 with cnt=5 -> next cycle phase=0, cnt=0, toggle=0, div back to 4. Force cnt_width=4 run -> cnt wraps 15->0.

Source files
------------

// File: rtl/tick_divider.sv
// tick_divider: multi-channel clock-enable generator with per-channel tick, toggle and tick counter
module tick_divider #(
   parameter int num_ch = 2,
   parameter int div_width = 16,
   parameter int cnt_width = 32,
   parameter logic [num_ch*div_width-1:0] div_default = {16'd9, 16'd4},
   localparam int ch_w = (num_ch > 1) ? $clog2(num_ch) : 1
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [num_ch-1:0]           i_enable,
   input  logic                        i_wr_valid,
   input  logic [ch_w-1:0]             i_wr_ch,
   input  logic [div_width-1:0]        i_wr_div,
   output logic                        o_wr_ready,
   output logic                        o_wr_err,
   output logic [num_ch*div_width-1:0] o_div,
   output logic [num_ch-1:0]           o_tick,
   output logic [num_ch-1:0]           o_toggle,
   output logic [num_ch*cnt_width-1:0] o_cnt
);
   logic w_wr_bad;
   logic r_wr_err;
   assign o_wr_ready = ~i_reset;
   assign w_wr_bad = {1'b0, i_wr_ch} >= (ch_w + 1)'(num_ch);
   assign o_wr_err = r_wr_err;
   always_ff @(posedge i_clock)
      if (i_reset) r_wr_err <= 1'b0;
      else r_wr_err <= i_wr_valid & w_wr_bad;
   for (genvar i = 0; i < num_ch; i++) begin : g_ch
      logic [div_width-1:0] r_phase, r_div;
      logic [cnt_width-1:0] r_cnt;
      logic r_tick, r_toggle, w_wr;
      assign w_wr = i_wr_valid & o_wr_ready & (i_wr_ch == ch_w'(i));
      assign o_div[i*div_width +: div_width] = r_div;
      assign o_cnt[i*cnt_width +: cnt_width] = r_cnt;
      assign o_tick[i] = r_tick;
      assign o_toggle[i] = r_toggle;
      // a divisor write restarts the period and suppresses any coincident tick
      always_ff @(posedge i_clock)
         if (i_reset) begin
            r_phase <= '0;
            r_div <= div_default[i*div_width +: div_width];
            r_tick <= 1'b0;
            r_toggle <= 1'b0;
            r_cnt <= '0;
         end else if (w_wr) begin
            r_phase <= '0;
            r_div <= i_wr_div;
            r_tick <= 1'b0;
         end else if (i_enable[i] && r_phase == r_div) begin
            r_phase <= '0;
            r_tick <= 1'b1;
            r_toggle <= ~r_toggle;
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_phase <= i_enable[i] ? r_phase + 1'b1 : r_phase;
            r_tick <= 1'b0;
         end
   end
endmodule

// File: tb/tb_tick_divider.sv
// tb_tick_divider: directed checks of tick_divider on the default, 3-channel and 4-bit-counter builds
module tb_tick_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int fails = 0;

   logic [1:0]  en = 2'b11;
   logic        wv = 1'b0;
   logic        wch = 1'b0;
   logic [15:0] wd = '0;
   logic        wr_ready, wr_err;
   logic [31:0] div;
   logic [1:0]  tick, tog;
   logic [63:0] cnt;

   logic [2:0]  en3 = 3'b111;
   logic        wv3 = 1'b0;
   logic [1:0]  wch3 = '0;
   logic [15:0] wd3 = '0;
   logic        wr_ready3, wr_err3;
   logic [47:0] div3;
   logic [2:0]  tick3, tog3;
   logic [95:0] cnt3;

   logic        enc = 1'b1;
   logic        wvc = 1'b0;
   logic        wchc = 1'b0;
   logic [15:0] wdc = '0;
   logic        wr_readyc, wr_errc;
   logic [15:0] divc;
   logic        tickc, togc;
   logic [3:0]  cntc;

   always #5 clk = ~clk;

   tick_divider dut (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_wr_valid(wv), .i_wr_ch(wch), .i_wr_div(wd),
      .o_wr_ready(wr_ready), .o_wr_err(wr_err), .o_div(div), .o_tick(tick), .o_toggle(tog), .o_cnt(cnt)
   );

   tick_divider #(.num_ch(3), .div_default({16'd7, 16'd9, 16'd4})) dut3 (
      .i_clock(clk), .i_reset(rst), .i_enable(en3), .i_wr_valid(wv3), .i_wr_ch(wch3), .i_wr_div(wd3),
      .o_wr_ready(wr_ready3), .o_wr_err(wr_err3), .o_div(div3), .o_tick(tick3), .o_toggle(tog3), .o_cnt(cnt3)
   );

   tick_divider #(.num_ch(1), .cnt_width(4), .div_default(16'd0)) dutc (
      .i_clock(clk), .i_reset(rst), .i_enable(enc), .i_wr_valid(wvc), .i_wr_ch(wchc), .i_wr_div(wdc),
      .o_wr_ready(wr_readyc), .o_wr_err(wr_errc), .o_div(divc), .o_tick(tickc), .o_toggle(togc), .o_cnt(cntc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      step();
      step();
      chk("rst_div", div, 32'h0009_0004);
      chk("rst_tick", tick, 0);
      chk("rst_tog", tog, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_wr_ready", wr_ready, 0);
      rst = 1'b0;
      #1;
      chk("wr_ready_up", wr_ready, 1);
      // defaults, all enabled for 40 cycles
      for (int t = 1; t <= 40; t++) begin
         step();
         chk("run_tick0", tick[0], (t % 5 == 0));
         chk("run_tick1", tick[1], (t % 10 == 0));
         chk("run_tog0", tog[0], (t / 5) % 2);
         chk("run_tog1", tog[1], (t / 10) % 2);
      end
      chk("run_cnt0", cnt[31:0], 8);
      chk("run_cnt1", cnt[63:32], 4);
      // write ch1 on its terminal-count edge (edge 50)
      for (int t = 41; t <= 49; t++) step();
      wv = 1'b1; wch = 1'b1; wd = 16'd2;
      step();
      wv = 1'b0;
      chk("wtc_tick1", tick[1], 0);
      chk("wtc_cnt1", cnt[63:32], 4);
      chk("wtc_div1", div[31:16], 2);
      chk("wtc_tick0", tick[0], 1);
      chk("wtc_cnt0", cnt[31:0], 10);
      step();
      chk("wtc_tick1_51", tick[1], 0);
      step();
      chk("wtc_tick1_52", tick[1], 0);
      step();
      chk("wtc_tick1_53", tick[1], 1);
      chk("wtc_cnt1_53", cnt[63:32], 5);
      chk("wtc_tog1_53", tog[1], 1);
      // hold ch0 at phase 2 (after edge 57) for 7 cycles
      for (int t = 54; t <= 57; t++) step();
      en = 2'b10;
      for (int k = 0; k < 7; k++) begin
         step();
         chk("hold_tick0", tick[0], 0);
         chk("hold_tog0", tog[0], 1);
         chk("hold_cnt0", cnt[31:0], 11);
      end
      en = 2'b11;
      step();
      chk("resume_tick0_a", tick[0], 0);
      step();
      chk("resume_tick0_b", tick[0], 0);
      step();
      chk("resume_tick0_c", tick[0], 1);
      chk("resume_cnt0", cnt[31:0], 12);
      chk("resume_tog0", tog[0], 0);
      // ch0 divisor 0: tick every cycle
      wv = 1'b1; wch = 1'b0; wd = 16'd0;
      step();
      wv = 1'b0;
      chk("d0_tick0_wr", tick[0], 0);
      chk("d0_div0", div[15:0], 0);
      chk("d0_tog0_wr", tog[0], 0);
      chk("d0_div1", div[31:16], 2);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("d0_tick0", tick[0], 1);
         chk("d0_tog0", tog[0], k % 2);
      end
      chk("d0_cnt0", cnt[31:0], 15);
      // mid-period reset at ch0 phase 3 with cnt 5
      rst = 1'b1;
      step();
      chk("rst2_div", div, 32'h0009_0004);
      rst = 1'b0;
      for (int t = 1; t <= 28; t++) step();
      chk("pre_cnt0", cnt[31:0], 5);
      chk("pre_tog0", tog[0], 1);
      rst = 1'b1;
      step();
      chk("mid_cnt0", cnt[31:0], 0);
      chk("mid_tog0", tog[0], 0);
      chk("mid_tick0", tick[0], 0);
      chk("mid_div", div, 32'h0009_0004);
      chk("mid_wr_ready", wr_ready, 0);
      rst = 1'b0;
      // phase restarts from 0; 4-bit counter wraps 15 -> 0
      for (int e = 1; e <= 16; e++) begin
         step();
         chk("post_tick0", tick[0], (e % 5 == 0));
         chk("wrap_cntc", cntc, e % 16);
      end
      // invalid channel on the 3-channel build
      wv3 = 1'b1; wch3 = 2'd3; wd3 = 16'h55;
      step();
      wv3 = 1'b0;
      chk("bad_wr_err", wr_err3, 1);
      chk("bad_div3", div3, 48'h0007_0009_0004);
      step();
      chk("bad_wr_err_end", wr_err3, 0);
      chk("bad_div3_end", div3, 48'h0007_0009_0004);
      wv3 = 1'b1; wch3 = 2'd2; wd3 = 16'd5;
      step();
      wv3 = 1'b0;
      chk("ok_wr_err", wr_err3, 0);
      chk("ok_div3", div3, 48'h0005_0009_0004);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
